// File: rtl/fp_pkg.sv
// Shared widths and stage-1 control bundle for the FP adder alignment path.
package fp_pkg;
    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 24;

    typedef struct packed {
        logic big_sign;
        logic small_sign;
        logic swapped;
    } fp_s1_ctl_t;
endpackage

// File: rtl/fp_rshift_sticky.sv
// Saturating right shifter with sticky OR of the bits shifted out.
// Sticky generation is only built when FP_ALIGN_STICKY_EN is defined.
module fp_rshift_sticky #(
    parameter int W    = 26,
    parameter int SH_W = 8
) (
    input  logic [W-1:0]    i_data,
    input  logic [SH_W-1:0] i_shamt,
    output logic [W-1:0]    o_data,
    output logic            o_sticky
);
    logic [31:0] w_sh;

    assign w_sh   = (32'(i_shamt) >= 32'(W)) ? 32'(W) : 32'(i_shamt);
    assign o_data = i_data >> w_sh;

`ifdef FP_ALIGN_STICKY_EN
    logic [W-1:0] w_lost;

    for (genvar gi = 0; gi < W; gi++) begin : g_lost
        assign w_lost[gi] = i_data[gi] && (32'(gi) < w_sh);
    end
    assign o_sticky = |w_lost;
`else
    assign o_sticky = 1'b0;
`endif
endmodule

// File: rtl/fp_align_stage.sv
// Two-stage exponent alignment with valid/ready handshake.
// Optional sticky generation: define FP_ALIGN_STICKY_EN.
module fp_align_stage
    import fp_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             a_sign,
    input  logic             b_sign,
    input  logic [EXP_W-1:0] a_exp,
    input  logic [EXP_W-1:0] b_exp,
    input  logic [MAN_W-1:0] a_man,
    input  logic [MAN_W-1:0] b_man,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXP_W-1:0] out_exp,
    output logic             big_sign,
    output logic             small_sign,
    output logic [MAN_W-1:0] big_man,
    output logic [MAN_W+1:0] small_man,
    output logic             sticky,
    output logic             swapped,
    output logic [EXP_W-1:0] diff
);
    localparam int SM_W = MAN_W + 2;

    logic             w_en1;
    logic             w_en2;
    logic [EXP_W:0]   w_ab;
    logic [EXP_W-1:0] w_ba;
    logic             w_swap;
    logic [SM_W-1:0]  w_shifted;
    logic             w_sticky;

    logic             r_s1_valid;
    fp_s1_ctl_t       r_s1_ctl;
    logic [EXP_W-1:0] r_s1_exp;
    logic [MAN_W-1:0] r_s1_big_man;
    logic [MAN_W-1:0] r_s1_small_man;
    logic [EXP_W-1:0] r_s1_diff;

    assign w_en2    = !out_valid || out_ready;
    assign w_en1    = !r_s1_valid || w_en2;
    assign in_ready = w_en1 && !reset;

    // Extra top bit of a-b is the borrow: set exactly when b_exp > a_exp.
    assign w_ab   = {1'b0, a_exp} - {1'b0, b_exp};
    assign w_ba   = b_exp - a_exp;
    assign w_swap = w_ab[EXP_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid     <= 1'b0;
            r_s1_ctl       <= '0;
            r_s1_exp       <= '0;
            r_s1_big_man   <= '0;
            r_s1_small_man <= '0;
            r_s1_diff      <= '0;
        end else if (w_en1) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_ctl.swapped    <= w_swap;
                r_s1_ctl.big_sign   <= w_swap ? b_sign : a_sign;
                r_s1_ctl.small_sign <= w_swap ? a_sign : b_sign;
                r_s1_exp            <= w_swap ? b_exp  : a_exp;
                r_s1_big_man        <= w_swap ? b_man  : a_man;
                r_s1_small_man      <= w_swap ? a_man  : b_man;
                r_s1_diff           <= w_swap ? w_ba   : w_ab[EXP_W-1:0];
            end
        end
    end

    fp_rshift_sticky #(
        .W    (SM_W),
        .SH_W (EXP_W)
    ) u_shift (
        .i_data   ({r_s1_small_man, 2'b00}),
        .i_shamt  (r_s1_diff),
        .o_data   (w_shifted),
        .o_sticky (w_sticky)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_exp    <= '0;
            big_sign   <= 1'b0;
            small_sign <= 1'b0;
            big_man    <= '0;
            small_man  <= '0;
            sticky     <= 1'b0;
            swapped    <= 1'b0;
            diff       <= '0;
        end else if (w_en2) begin
            out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                out_exp    <= r_s1_exp;
                big_sign   <= r_s1_ctl.big_sign;
                small_sign <= r_s1_ctl.small_sign;
                big_man    <= r_s1_big_man;
                small_man  <= w_shifted;
                sticky     <= w_sticky;
                swapped    <= r_s1_ctl.swapped;
                diff       <= r_s1_diff;
            end
        end
    end
endmodule
